// File: rtl/mul_product_uart_tx_pkg.sv
// -----------------------------------------------------------------------------
// mul_uart_pkg
// Shared types and constants for the multiplier-product UART transmitter.
//   tx_state_e : transmitter frame state (IDLE, START, DATA, STOP)
//   DATA_BITS  : product width carried in each frame
//   BIT_CNT_W  : width of the data-bit index counter
// -----------------------------------------------------------------------------
package mul_uart_pkg;

  localparam int DATA_BITS = 8;
  localparam int BIT_CNT_W = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_e;

endpackage : mul_uart_pkg

// File: rtl/mul_product_uart_tx_if.sv
// -----------------------------------------------------------------------------
// mul_product_uart_tx_if
// Valid/ready handshake carrying one product from the multiplier array to the
// UART transmitter.
//   in_product : product value (DATA_BITS wide)
//   in_valid   : producer has a product on in_product
//   in_ready   : consumer buffer is empty; transfer when valid && ready
// Modports:
//   master : producer side (multiplier front-end)
//   slave  : consumer side (UART transmitter)
// -----------------------------------------------------------------------------
interface mul_product_uart_tx_if;
  import mul_uart_pkg::*;

  logic [DATA_BITS-1:0] in_product;
  logic                 in_valid;
  logic                 in_ready;

  modport master (
    output in_product,
    output in_valid,
    input  in_ready
  );

  modport slave (
    input  in_product,
    input  in_valid,
    output in_ready
  );

endinterface : mul_product_uart_tx_if

// File: rtl/mul_product_uart_tx_baud_counter.sv
// -----------------------------------------------------------------------------
// uart_baud_counter
// Counts 0..CLKS_PER_BIT-1 while enabled and flags the last cycle of each bit
// period. Kept generic so the UART RX operand loader can reuse it.
// Ports:
//   clk     : system clock
//   rst_n   : asynchronous active-low reset
//   clear   : synchronous restart of the count at 0 (wins over enable)
//   enable  : count advances when high
//   bit_end : high during the final cycle of a bit period (count == last)
// -----------------------------------------------------------------------------
module uart_baud_counter #(
  parameter int CLKS_PER_BIT = 87
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic bit_end
);

  localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (enable) begin
      // Wrap at the end of each bit so consecutive bits need no explicit clear.
      cnt_q <= bit_end ? '0 : cnt_q + CNT_W'(1);
    end
  end

  assign bit_end = enable && (cnt_q == CNT_LAST);

endmodule : uart_baud_counter

// File: rtl/mul_product_uart_tx.sv
// -----------------------------------------------------------------------------
// mul_product_uart_tx
// Takes 8-bit products from the Vedic multiplier array over a valid/ready
// handshake into a one-deep holding buffer and serialises each one on the UART
// TX pin as an 8N1 frame (start 0, 8 data bits LSB first, stop 1). The buffer
// lets the next product arrive while the current frame is on the wire; a
// buffered product follows the previous stop bit with no idle gap.
// Ports:
//   clk      : system clock
//   rst_n    : asynchronous active-low reset (abandons frame and buffer)
//   in_if    : slave handshake (in_product, in_valid, in_ready)
//   uart_tx  : serial line, idle high, registered
//   tx_busy  : frame in progress or buffer occupied, registered
//   tx_done  : one-cycle pulse after each completed stop bit, registered
// -----------------------------------------------------------------------------
module mul_product_uart_tx
  import mul_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 87
) (
  input  logic                  clk,
  input  logic                  rst_n,
  mul_product_uart_tx_if.slave  in_if,
  output logic                  uart_tx,
  output logic                  tx_busy,
  output logic                  tx_done
);

  localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(DATA_BITS - 1);

  tx_state_e              state_q, state_d;
  logic [BIT_CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic                   hold_valid_q, hold_valid_d;
  logic                   tx_q, tx_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   ready_q, ready_d;
  logic [DATA_BITS-1:0]   hold_q;
  logic [DATA_BITS-1:0]   shift_q;

  logic                   accept;
  logic                   load;
  logic                   shift;
  logic                   bit_end;
  logic                   baud_clear;
  logic                   baud_en;

  // ready_q always equals !hold_valid_q, so an accept can never coincide with
  // the buffer draining into the shifter.
  assign accept = in_if.in_valid && ready_q;

  assign baud_en    = (state_q != IDLE);
  assign baud_clear = (state_q == IDLE) || (state_d != state_q);

  uart_baud_counter #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_baud (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (baud_clear),
    .enable  (baud_en),
    .bit_end (bit_end)
  );

  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    hold_valid_d = hold_valid_q;
    tx_d         = tx_q;
    done_d       = 1'b0;
    load         = 1'b0;
    shift        = 1'b0;

    unique case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (hold_valid_q) begin
          load    = 1'b1;
          state_d = START;
          tx_d    = 1'b0;
        end
      end

      START: begin
        if (bit_end) begin
          state_d   = DATA;
          bit_cnt_d = '0;
          tx_d      = shift_q[0];
        end
      end

      DATA: begin
        if (bit_end) begin
          if (bit_cnt_q == LAST_BIT) begin
            state_d = STOP;
            tx_d    = 1'b1;
          end else begin
            bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
            shift     = 1'b1;
            // The register shifts at this edge, so the next bit is shift_q[1].
            tx_d      = shift_q[1];
          end
        end
      end

      STOP: begin
        if (bit_end) begin
          done_d = 1'b1;
          if (hold_valid_q) begin
            // Chain straight into the next start bit: no idle-high cycle.
            load    = 1'b1;
            state_d = START;
            tx_d    = 1'b0;
          end else begin
            state_d = IDLE;
            tx_d    = 1'b1;
          end
        end
      end

      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
      end
    endcase

    if (accept) begin
      hold_valid_d = 1'b1;
    end else if (load) begin
      hold_valid_d = 1'b0;
    end
  end

  // Status outputs are registered from the next-state values so they line up
  // with the state they describe.
  assign ready_d = !hold_valid_d;
  assign busy_d  = (state_d != IDLE) || hold_valid_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      bit_cnt_q    <= '0;
      hold_valid_q <= 1'b0;
      tx_q         <= 1'b1;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      ready_q      <= 1'b1;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      hold_valid_q <= hold_valid_d;
      tx_q         <= tx_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      ready_q      <= ready_d;
    end
  end

  // Data registers carry no reset: their contents are only observed while the
  // matching control flag (hold_valid_q / state_q) says they are valid.
  always_ff @(posedge clk) begin
    if (accept) begin
      hold_q <= in_if.in_product;
    end
    if (load) begin
      shift_q <= hold_q;
    end else if (shift) begin
      shift_q <= {1'b0, shift_q[DATA_BITS-1:1]};
    end
  end

  assign in_if.in_ready = ready_q;
  assign uart_tx        = tx_q;
  assign tx_busy        = busy_q;
  assign tx_done        = done_q;

endmodule : mul_product_uart_tx

// File: tb/tb_mul_product_uart_tx.sv
// -----------------------------------------------------------------------------
// tb_mul_product_uart_tx
// Two instances: index 0 with CLKS_PER_BIT=4, index 1 with the default 87.
// Stimulus pushes {product, expected start edge} into a per-instance queue; a
// per-instance monitor decodes frames from uart_tx and compares.
// -----------------------------------------------------------------------------
module tb_mul_product_uart_tx;
  import mul_uart_pkg::*;

  typedef struct {
    logic [7:0] data;
    int         start;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n [2];
  logic [7:0] prod  [2];
  logic       vld   [2];
  logic       rdy   [2];
  logic       tx    [2];
  logic       busy  [2];
  logic       done  [2];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int   checks = 0;
  int   errors = 0;
  exp_t exp_q [2][$];
  int   last_start [2];

  function automatic int clks(input int g);
    return (g == 0) ? 4 : 87;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int C = (g == 0) ? 4 : 87;

    mul_product_uart_tx_if ifc ();
    assign ifc.in_product = prod[g];
    assign ifc.in_valid   = vld[g];
    assign rdy[g]         = ifc.in_ready;

    mul_product_uart_tx #(.CLKS_PER_BIT(C)) dut (
      .clk     (clk),
      .rst_n   (rst_n[g]),
      .in_if   (ifc),
      .uart_tx (tx[g]),
      .tx_busy (busy[g]),
      .tx_done (done[g])
    );

    logic       in_frame;
    logic       done_exp;
    logic       stable;
    int         slot;
    int         cnt;
    int         t0;
    logic       line [10];
    logic [7:0] got;
    exp_t       e;

    initial begin
      in_frame = 1'b0;
      done_exp = 1'b0;
      stable   = 1'b1;
      slot     = 0;
      cnt      = 0;
      t0       = 0;
      forever begin
        @(negedge clk);
        if (rst_n[g] !== 1'b1) begin
          in_frame = 1'b0;
          done_exp = 1'b0;
        end else begin
          if (done_exp) begin
            checks++;
            if (done[g] !== 1'b1) begin
              errors++;
              $display("FAIL tx_done_pulse dut%0d edge %0d: got %b want 1", g, cyc, done[g]);
            end
            done_exp = 1'b0;
          end else if (done[g] !== 1'b0) begin
            checks++;
            errors++;
            $display("FAIL tx_done_spurious dut%0d edge %0d: got %b want 0", g, cyc, done[g]);
          end

          if (!in_frame) begin
            if (tx[g] === 1'b0) begin
              in_frame = 1'b1;
              slot     = 0;
              cnt      = 1;
              line[0]  = 1'b0;
              t0       = cyc;
              stable   = 1'b1;
            end
          end else if (cnt == C) begin
            slot++;
            cnt        = 1;
            line[slot] = tx[g];
          end else begin
            cnt++;
            if (tx[g] !== line[slot]) stable = 1'b0;
          end

          if (in_frame && slot == 9 && cnt == C) begin
            for (int i = 0; i < 8; i++) got[i] = line[i+1];
            if (exp_q[g].size() == 0) begin
              checks++;
              errors++;
              $display("FAIL unexpected_frame dut%0d: got 0x%02h want no frame", g, got);
            end else begin
              e = exp_q[g].pop_front();
              checks++;
              if (got !== e.data) begin
                errors++;
                $display("FAIL frame_data dut%0d: got 0x%02h want 0x%02h", g, got, e.data);
              end
              checks++;
              if (t0 != e.start) begin
                errors++;
                $display("FAIL start_edge dut%0d: got %0d want %0d", g, t0, e.start);
              end
              checks++;
              if (line[9] !== 1'b1) begin
                errors++;
                $display("FAIL stop_bit dut%0d: got %b want 1", g, line[9]);
              end
              checks++;
              if (!stable) begin
                errors++;
                $display("FAIL bit_width dut%0d: got unstable bit want %0d-cycle bits", g, C);
              end
            end
            in_frame = 1'b0;
            done_exp = 1'b1;
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic got, input logic want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %b want %b", name, got, want);
    end
  endtask

  task automatic chk_int(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  // Called just after a negedge; returns at the negedge after the accept edge.
  task automatic send(input int g, input logic [7:0] d);
    int n;
    int acc;
    int st;
    n       = 0;
    prod[g] = d;
    vld[g]  = 1'b1;
    while (rdy[g] !== 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (rdy[g] !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout dut%0d: got in_ready %b want 1", g, rdy[g]);
      vld[g] = 1'b0;
      return;
    end
    acc = cyc + 1;
    st  = acc + 1;
    if (last_start[g] + 10 * clks(g) > st) st = last_start[g] + 10 * clks(g);
    exp_q[g].push_back('{data: d, start: st});
    last_start[g] = st;
    @(negedge clk);
    vld[g] = 1'b0;
    chk("in_ready_after_accept", rdy[g], 1'b0);
  endtask

  task automatic drain(input int g, output int edge_seen);
    int n;
    n = 0;
    while (!(exp_q[g].size() == 0 && busy[g] === 1'b0) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout dut%0d: got busy %b want 0", g, busy[g]);
    end
    edge_seen = cyc;
  endtask

  task automatic chk_reset(input int g);
    chk("reset_uart_tx", tx[g], 1'b1);
    chk("reset_in_ready", rdy[g], 1'b1);
    chk("reset_tx_busy", busy[g], 1'b0);
    chk("reset_tx_done", done[g], 1'b0);
  endtask

  int edge_seen;
  int n;

  initial begin
    rst_n      = '{1'b1, 1'b1};
    vld        = '{1'b0, 1'b0};
    prod       = '{8'h00, 8'h00};
    last_start = '{-100000, -100000};

    // Reset takes effect before any clock edge.
    #2 rst_n = '{1'b0, 1'b0};
    #1;
    chk_reset(0);
    chk_reset(1);
    repeat (2) @(negedge clk);
    rst_n = '{1'b1, 1'b1};
    @(negedge clk);

    // Single frame 0xE1.
    send(0, 8'hE1);
    @(negedge clk);
    chk("in_ready_reload", rdy[0], 1'b1);
    chk("tx_busy_frame", busy[0], 1'b1);
    drain(0, edge_seen);
    chk_int("busy_fall_e1", edge_seen, last_start[0] + 40);
    chk("idle_line_e1", tx[0], 1'b1);

    // Back-to-back: 0x24 accepted during the DATA phase of 0x00.
    send(0, 8'h00);
    repeat (8) @(negedge clk);
    send(0, 8'h24);
    drain(0, edge_seen);
    chk_int("busy_fall_b2b", edge_seen, last_start[0] + 40);

    // Backpressure: 0x51 held while the buffer is full.
    send(0, 8'h3C);
    send(0, 8'h99);
    prod[0] = 8'h51;
    vld[0]  = 1'b1;
    for (int i = 0; i < 20; i++) begin
      chk("in_ready_backpressure", rdy[0], 1'b0);
      @(negedge clk);
    end
    send(0, 8'h51);
    drain(0, edge_seen);
    chk_int("busy_fall_bp", edge_seen, last_start[0] + 40);

    // Reset during data bit 3 of 0xFF, then a clean 0x01 frame.
    send(0, 8'hFF);
    n = 0;
    while (cyc < last_start[0] + 17 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("busy_mid_frame", busy[0], 1'b1);
    #1 rst_n[0] = 1'b0;
    #1;
    chk_reset(0);
    exp_q[0].delete();
    last_start[0] = -100000;
    repeat (2) @(negedge clk);
    rst_n[0] = 1'b1;
    @(negedge clk);
    send(0, 8'h01);
    drain(0, edge_seen);
    chk_int("busy_fall_after_reset", edge_seen, last_start[0] + 40);

    // Default bit time: 0x55 gives an alternating 0101010101 line.
    send(1, 8'h55);
    drain(1, edge_seen);
    chk_int("frame_len_87", edge_seen - last_start[1], 870);
    chk("idle_line_87", tx[1], 1'b1);

    repeat (3) @(negedge clk);
    chk_int("queue_empty_dut0", exp_q[0].size(), 0);
    chk_int("queue_empty_dut1", exp_q[1].size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_mul_product_uart_tx
